// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Memory-mapped scan controller for two 4-digit 7-segment displays. Holds a
// 32-bit DATA register written by the CPU through the bridge, and a display
// buffer that is refreshed from DATA only when the digit scan wraps, so a
// display never shows a half-updated value.
//
// Ports
//   clk    : system clock, all state changes on the rising edge
//   rst    : synchronous reset, active-high
//   addr   : register select (0 DATA, 1 CTRL, 2 DIV, 3 STATUS)
//   din    : CPU write data
//   be     : byte enables for din
//   we     : write strobe
//   dout   : combinational read data for addr
//   dout1  : segments of display 1 (buffer bits 15:0), active-low {dp,g..a}
//   dout2  : segments of display 2 (buffer bits 31:16), same coding
//   sel1   : digit select of display 1, one-hot active-low, sel1[1] = LSD
//   sel2   : digit select of display 2, same coding
//   frame  : one-cycle pulse in the cycle whose edge reloads the buffer
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'd49999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:2]  addr,
  input  logic [31:0] din,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] dout,
  output logic [7:0]  dout1,
  output logic [7:0]  dout2,
  output logic [4:1]  sel1,
  output logic [4:1]  sel2,
  output logic        frame
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Byte-lane merge of a CPU write into an existing 32-bit register.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = lanes[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
    end
    return res;
  endfunction

  // Hex nibble to active-low segment pattern, dp always off.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // A digit is a leading zero when it and every more-significant digit of
  // its display are zero. The least-significant digit always shows, so a
  // display of value zero still reads "0".
  function automatic logic digit_blank(input logic [15:0] half,
                                       input logic [1:0]  idx);
    logic [15:0] upper;
    upper = half >> {idx, 2'b00};
    return (idx != 2'd0) && (upper == 16'h0000);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] data_q;
  logic        en_q;
  logic        lzb_q;
  logic [15:0] div_q;
  logic [31:0] disp_buf;
  logic [15:0] cnt_q;
  logic [1:0]  idx_q;

  logic        scan_tick;
  logic        frame_edge;
  logic        wr_data;
  logic        wr_ctrl;
  logic        wr_div;
  logic [15:0] div_next;

  // The >= compare (not ==) lets a DIV write below the running count end the
  // current digit on the next clock instead of waiting for a 16-bit wrap.
  assign scan_tick  = (cnt_q >= div_q);
  assign frame_edge = scan_tick && (idx_q == 2'd3);

  // Reset overrides the reload, so no pulse is reported in a reset cycle.
  assign frame = frame_edge && !rst;

  assign wr_data = we && (addr == ADDR_DATA);
  assign wr_ctrl = we && (addr == ADDR_CTRL);
  assign wr_div  = we && (addr == ADDR_DIV);

  assign div_next = {be[1] ? din[15:8] : div_q[15:8],
                     be[0] ? din[7:0]  : div_q[7:0]};

  // ---------------------------------------------------------------------------
  // Scan divider, digit index, frame reload and register writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'h0;
      en_q     <= 1'b1;
      lzb_q    <= 1'b0;
      div_q    <= DIV_RESET;
      disp_buf <= 32'h0;
      cnt_q    <= 16'h0;
      idx_q    <= 2'd0;
    end else begin
      if (scan_tick) begin
        cnt_q <= 16'h0;
        // idx wraps 3 -> 0 naturally in two bits.
        idx_q <= idx_q + 2'd1;
        // data_q here is the pre-write value, so a write landing on the
        // boundary cycle waits for the next frame.
        if (frame_edge) begin
          disp_buf <= data_q;
        end
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (wr_data) begin
        data_q <= merge_bytes(data_q, din, be);
      end
      if (wr_ctrl && be[0]) begin
        en_q  <= din[0];
        lzb_q <= din[1];
      end
      if (wr_div) begin
        div_q <= div_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic [15:0] half1;
  logic [15:0] half2;
  logic [3:0]  nib1;
  logic [3:0]  nib2;
  logic [3:0]  sel_n;

  assign half1 = disp_buf[15:0];
  assign half2 = disp_buf[31:16];
  assign nib1  = half1[{idx_q, 2'b00} +: 4];
  assign nib2  = half2[{idx_q, 2'b00} +: 4];
  assign sel_n = ~(4'b0001 << idx_q);

  always_comb begin
    sel1  = 4'hF;
    sel2  = 4'hF;
    dout1 = 8'hFF;
    dout2 = 8'hFF;
    // With EN low everything stays dark but scanning continues underneath.
    if (en_q) begin
      sel1  = sel_n;
      sel2  = sel_n;
      dout1 = (lzb_q && digit_blank(half1, idx_q)) ? 8'hFF : seg_encode(nib1);
      dout2 = (lzb_q && digit_blank(half2, idx_q)) ? 8'hFF : seg_encode(nib2);
    end
  end

  always_comb begin
    dout = 32'h0;
    case (addr)
      ADDR_DATA:   dout = data_q;
      ADDR_CTRL:   dout = {30'h0, lzb_q, en_q};
      ADDR_DIV:    dout = {16'h0, div_q};
      ADDR_STATUS: dout = {30'h0, idx_q};
      default:     dout = 32'h0;
    endcase
  end

endmodule
